// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings, FSM/ALU enums and helpers for the multicycle core
package mips_pkg;
  localparam int REG_AW = 5;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2a;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 2R1W register file with debug read; gr0 and indices >= NREG read zero
module mips_regfile
  import mips_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] dbg_ra,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [31:0]       wd,
  output logic [31:0]       rd1,
  output logic [31:0]       rd2,
  output logic [31:0]       dbg_rd
);
  localparam int AW = $clog2(NREG);
  localparam logic [REG_AW:0] LIM = (REG_AW + 1)'(NREG);
  logic [31:0] gr [NREG];
  function automatic logic ok(input logic [REG_AW-1:0] i);
    return i != '0 && {1'b0, i} < LIM;
  endfunction
  assign rd1    = ok(ra1) ? gr[ra1[AW-1:0]] : '0;
  assign rd2    = ok(ra2) ? gr[ra2[AW-1:0]] : '0;
  assign dbg_rd = ok(dbg_ra) ? gr[dbg_ra[AW-1:0]] : '0;
  always_ff @(posedge clock)
    if (!resetn) for (int i = 0; i < NREG; i++) gr[i] <= '0;
    else if (we && ok(wa)) gr[wa[AW-1:0]] <= wd;
endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: five-state multicycle MIPS-subset core with req/ack memory ports
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREG     = 32
) (
  input  logic              clock,
  input  logic              resetn,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [31:0]       dbg_rdata,
  output logic [31:0]       pc,
  output logic              halted
);
  state_e state, nxt;
  alu_op_e alu_op;
  logic [31:0] ir, a, b, imm, res, mdr, rd1, rd2, src2, alu_y, pc4;
  logic [5:0] op, fn;
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, r_ok, legal;
  assign op      = ir[31:26];
  assign fn      = ir[5:0];
  assign is_r    = op == OP_R;
  assign is_lw   = op == OP_LW;
  assign is_sw   = op == OP_SW;
  assign is_beq  = op == OP_BEQ;
  assign is_addi = op == OP_ADDI;
  assign is_j    = op == OP_J;
  assign r_ok    = is_r && (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT);
  assign legal   = r_ok || is_lw || is_sw || is_beq || is_addi || is_j;
  assign pc4     = pc + 32'd4;
  assign src2    = is_r ? b : imm;
  always_comb begin
    alu_op = !is_r ? ALU_ADD : fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND :
             fn == FN_OR ? ALU_OR : fn == FN_SLT ? ALU_SLT : ALU_ADD;
    alu_y  = alu_op == ALU_SUB ? a - src2 : alu_op == ALU_AND ? a & src2 :
             alu_op == ALU_OR ? a | src2 :
             alu_op == ALU_SLT ? {31'b0, $signed(a) < $signed(src2)} : a + src2;
  end
  mips_regfile #(.NREG(NREG)) u_rf (
    .clock (clock),
    .resetn(resetn),
    .ra1   (ir[25:21]),
    .ra2   (ir[20:16]),
    .dbg_ra(dbg_raddr),
    .we    (state == S_WB),
    .wa    (is_r ? ir[15:11] : ir[20:16]),
    .wd    (is_lw ? mdr : res),
    .rd1   (rd1),
    .rd2   (rd2),
    .dbg_rd(dbg_rdata)
  );
  // requests are gated by resetn so they drop in the reset cycle itself
  assign imem_req   = resetn && state == S_FETCH;
  assign imem_addr  = pc;
  assign dmem_req   = resetn && state == S_MEM;
  assign dmem_we    = dmem_req && is_sw;
  assign dmem_addr  = dmem_req ? res : '0;
  assign dmem_wdata = dmem_req ? b : '0;
  assign halted     = state == S_HALT;
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  nxt = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: nxt = legal ? S_EXEC : S_HALT;
      S_EXEC:   nxt = (is_beq || is_j) ? S_FETCH : (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:    nxt = !dmem_ack ? S_MEM : is_sw ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_HALT;
    endcase
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      imm   <= '0;
      res   <= '0;
      mdr   <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          a   <= rd1;
          b   <= rd2;
          imm <= sext16(ir[15:0]);
        end
        S_EXEC: begin
          res <= alu_y;
          if (is_beq) pc <= (a == b) ? pc4 + {imm[29:0], 2'b00} : pc4;
          if (is_j) pc <= {pc4[31:28], ir[25:0], 2'b00};
        end
        S_MEM: if (dmem_ack && is_sw) pc <= pc4;
               else if (dmem_ack) mdr <= dmem_rdata;
        S_WB: pc <= pc4;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: program-driven bench with memory responders and a store scoreboard
module tb_mips_multicycle;
  typedef struct {
    logic [31:0] pc, ins;
    int          iw, dw, cyc;
    logic [31:0] npc;
    logic [4:0]  ri;
    logic [31:0] rv;
    bit          st;
    logic [31:0] sa, sd;
  } vec_t;
  typedef struct {logic [31:0] a, d;} st_t;

  logic clock = 0, resetn = 0;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, dbg_rdata, pc;
  logic [4:0] dbg_raddr = 0;
  int total = 0, bad = 0, icnt = 0, dcnt = 0;
  logic [31:0] imem [256];
  int iw_tab [256], dw_tab [256];
  logic [31:0] dmem [logic [31:0]];
  st_t sbq [$];
  bit stray = 0;
  vec_t vec [16];

  mips_multicycle #(.RESET_PC(32'h0), .NREG(8)) dut (
    .clock(clock), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc), .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic store_chk();
    st_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL store_unexpected got addr=%h data=%h exp=none", dmem_addr, dmem_wdata);
    end else begin
      e = sbq.pop_front();
      chk("store_addr", dmem_addr, e.a);
      chk("store_data", dmem_wdata, e.d);
    end
  endtask

  // memory responders: wait states are looked up by the PC of the instruction in flight
  initial begin
    imem_ack = 0; dmem_ack = 0; imem_rdata = 0; dmem_rdata = 0;
    forever begin
      @(negedge clock);
      imem_ack = 0;
      dmem_ack = stray;
      if (!imem_req) icnt = 0;
      else if (icnt < iw_tab[pc[9:2]]) icnt++;
      else begin
        imem_ack = 1;
        imem_rdata = imem[imem_addr[9:2]];
        icnt = 0;
      end
      if (!dmem_req) dcnt = 0;
      else if (dcnt < dw_tab[pc[9:2]]) dcnt++;
      else begin
        dmem_ack = 1;
        dcnt = 0;
        if (dmem_we) store_chk();
        else dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : 32'h0;
      end
    end
  end

  task automatic step(output int cyc, output logic [31:0] npc);
    int n = 0;
    bit lo = 0;
    do begin
      @(negedge clock);
      n++;
      if (!imem_req) lo = 1;
    end while (!(lo && imem_req) && n < 200);
    cyc = n;
    npc = imem_addr;
  endtask

  task automatic reset_seq();
    @(negedge clock);
    resetn = 0;
    @(posedge clock);
    #1 resetn = 1;
    @(negedge clock);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] r, input logic [31:0] exp);
    dbg_raddr = r;
    #1 chk(nm, dbg_rdata, exp);
  endtask

  initial begin
    int cyc, n;
    logic [31:0] npc;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'hFC00_0000;
      iw_tab[i] = 0;
      dw_tab[i] = 0;
    end
    vec[0]  = '{32'h000, 32'h8C010001, 0, 0, 5,  32'h004, 5'd1, 32'h0000_00ab, 0, 0, 0};
    vec[1]  = '{32'h004, 32'h8C020002, 3, 3, 11, 32'h008, 5'd2, 32'h0000_3c00, 0, 0, 0};
    vec[2]  = '{32'h008, 32'h00221820, 0, 0, 4,  32'h00C, 5'd3, 32'h0000_3cab, 0, 0, 0};
    vec[3]  = '{32'h00C, 32'hAC03FFFF, 0, 0, 4,  32'h010, 5'd3, 32'h0000_3cab, 1, 32'hFFFF_FFFF, 32'h0000_3cab};
    vec[4]  = '{32'h010, 32'h10210002, 0, 0, 3,  32'h01C, 5'd1, 32'h0000_00ab, 0, 0, 0};
    vec[5]  = '{32'h01C, 32'h2004FFFF, 0, 0, 4,  32'h020, 5'd4, 32'hFFFF_FFFF, 0, 0, 0};
    vec[6]  = '{32'h020, 32'h20050001, 1, 0, 5,  32'h024, 5'd5, 32'h0000_0001, 0, 0, 0};
    vec[7]  = '{32'h024, 32'h0085302A, 0, 0, 4,  32'h028, 5'd6, 32'h0000_0001, 0, 0, 0};
    vec[8]  = '{32'h028, 32'h00223822, 0, 0, 4,  32'h02C, 5'd7, 32'hFFFF_C4AB, 0, 0, 0};
    vec[9]  = '{32'h02C, 32'h00E33824, 0, 0, 4,  32'h030, 5'd7, 32'h0000_04AB, 0, 0, 0};
    vec[10] = '{32'h030, 32'h00E23825, 0, 0, 4,  32'h034, 5'd7, 32'h0000_3CAB, 0, 0, 0};
    vec[11] = '{32'h034, 32'h08000040, 0, 0, 3,  32'h100, 5'd7, 32'h0000_3CAB, 0, 0, 0};
    vec[12] = '{32'h100, 32'h20000005, 0, 0, 4,  32'h104, 5'd0, 32'h0000_0000, 0, 0, 0};
    vec[13] = '{32'h104, 32'h20090005, 0, 0, 4,  32'h108, 5'd9, 32'h0000_0000, 0, 0, 0};
    vec[14] = '{32'h108, 32'h20070005, 0, 0, 4,  32'h10C, 5'd7, 32'h0000_0005, 0, 0, 0};
    vec[15] = '{32'h10C, 32'h10220002, 2, 0, 5,  32'h110, 5'd2, 32'h0000_3c00, 0, 0, 0};
    foreach (vec[i]) begin
      imem[vec[i].pc[9:2]] = vec[i].ins;
      iw_tab[vec[i].pc[9:2]] = vec[i].iw;
      dw_tab[vec[i].pc[9:2]] = vec[i].dw;
    end
    dmem[32'h1] = 32'h0000_00ab;
    dmem[32'h2] = 32'h0000_3c00;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_imem_req", {31'b0, imem_req}, 0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    rd_chk("rst_gr1", 5'd1, 0);
    @(posedge clock);
    #1 resetn = 1;
    @(negedge clock);
    chk("first_fetch_req", {31'b0, imem_req}, 1);

    foreach (vec[i]) begin
      if (vec[i].st) sbq.push_back('{vec[i].sa, vec[i].sd});
      step(cyc, npc);
      chk($sformatf("cycles@%h", vec[i].pc), 32'(cyc), 32'(vec[i].cyc));
      chk($sformatf("next_pc@%h", vec[i].pc), npc, vec[i].npc);
      rd_chk($sformatf("gr%0d@%h", vec[i].ri, vec[i].pc), vec[i].ri, vec[i].rv);
    end

    repeat (3) @(negedge clock);
    chk("illegal_halted", {31'b0, halted}, 1);
    chk("illegal_pc", pc, 32'h110);
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (imem_req || dmem_req) n++;
    end
    chk("halt_req_count", 32'(n), 0);

    imem[0] = 32'h00221821;
    reset_seq();
    chk("restart_pc", imem_addr, 0);
    repeat (3) @(negedge clock);
    chk("bad_funct_halted", {31'b0, halted}, 1);
    chk("bad_funct_pc", pc, 0);
    rd_chk("cleared_gr1", 5'd1, 0);
    rd_chk("cleared_gr3", 5'd3, 0);

    imem[0] = 32'hAC000004;
    dw_tab[0] = 1000;
    reset_seq();
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("sw_mem_reached", {31'b0, dmem_req}, 1);
    @(negedge clock);
    resetn = 0;
    #1;
    chk("mid_rst_dmem_req", {31'b0, dmem_req}, 0);
    chk("mid_rst_dmem_we", {31'b0, dmem_we}, 0);
    @(posedge clock);
    #1 resetn = 1;
    stray = 1;
    @(negedge clock);
    chk("late_ack_imem_req", {31'b0, imem_req}, 1);
    chk("late_ack_fetch_addr", imem_addr, 0);
    chk("late_ack_dmem_req", {31'b0, dmem_req}, 0);
    stray = 0;
    @(negedge clock);
    chk("late_ack_no_mem", {31'b0, dmem_req}, 0);
    chk("late_ack_not_halted", {31'b0, halted}, 0);
    chk("store_queue_left", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
